note_track_streamer: RTL
========================

# note_track_streamer

Multi-lane note streamer for the Guitar Hero datapath. It walks a preloaded song RAM one row per game tick and scrolls each row down a LANES-wide, DEPTH-tall note window, which drives the display and the hit-zone row. It is the parametrised successor of the single-lane 4-bit load/shift track. It adds multiple lanes, a prefetching RAM address sequencer, pause, loop and end-of-song drain, all clocked from one system clock with tick enables.

## Interface
- LANES, 4: note lanes; also the RAM word width.
- DEPTH, 8: window rows per lane (≥2).
- ADDR_W, 5: song RAM address width.
- SONG_LEN, 32: rows in the song (1..2^ADDR_W).
- LOOP, 0: 1 = wrap to address 0 after the last row; 0 = drain, then stop.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock (CLOCK_50 at top level).
- RESET_N  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; (re)starts playback from address 0.
- tick  in  1  single-cycle game-step pulse, synchronous to CLK.
- pause  in  1  level; ticks are ignored while high.
- mem_addr  out  ADDR_W  song RAM read address (registered).
- mem_rdata  in  LANES  song RAM data; valid 1 cycle after mem_addr is sampled.
- window  out  LANES*DEPTH  bit [r*LANES+l] = lane l, row r; row DEPTH-1 is the top (entry), row 0 is the hit zone.
- hit_row  out  LANES  equals window[LANES-1:0].
- busy  out  1  high in every state except IDLE and DONE.
- song_done  out  1  one-cycle pulse on entry to DONE.
- overrun  out  1  sticky; set when a tick is dropped. Cleared by start or reset.

## Operation
- States:
  - IDLE: reset state; waits for start.
  - FETCH: mem_addr presented.
  - WAIT: RAM latency; mem_rdata is captured into the prefetch register at the end of this cycle.
  - PLAY: prefetch valid; waits for a tick.
  - DRAIN: song exhausted; each tick shifts a zero row in.
  - DONE.
- On start (any state): window, prefetch, pending, drain count and overrun are cleared. Address is set to 0. Next state is FETCH. start takes priority over tick in the same cycle.
- Tick accepted (tick=1, pause=0):
  - In PLAY: every row r takes row r+1. The top row takes the prefetch value. The address advances. The state goes to FETCH.
  - In FETCH/WAIT: sets a one-deep pending flag. If pending is already set, the tick is dropped and overrun is set.
  - In PLAY with pending set: the pending tick is consumed first, identically, and pending clears.
  - In IDLE/DONE: ignored.
- Address advance after consuming row SONG_LEN-1:
  - LOOP=1: address goes to 0, then FETCH.
  - LOOP=0: go to DRAIN with the drain count at 0.
- DRAIN:
  - Each accepted tick shifts in an all-zero top row and increments the drain count.
  - When the count reaches DEPTH, the window is all zero: go to DONE and pulse song_done.
  - A pending flag held on entry is consumed as the first drain tick.
- pause only gates ticks. An in-flight FETCH/WAIT completes, and a pending tick set before pause remains.
- mem_addr holds its value outside FETCH.

## Timing
- Reset: window, hit_row, mem_addr, busy, song_done and overrun are all 0; state IDLE.
- start sampled at edge 0: FETCH during cycle 1, WAIT during cycle 2, PLAY from cycle 3.
- Tick in PLAY at edge n:
  - The window is updated at edge n.
  - FETCH runs in cycle n+1 and WAIT in cycle n+2.
  - PLAY resumes at n+3.
  - Minimum lossless tick spacing is 3 cycles; up to one tick inside that gap is absorbed by pending.
- A row written at the top reaches hit_row after DEPTH-1 further ticks.
- song_done is high exactly one cycle, the cycle after the final drain tick edge; busy falls in the same cycle.
- Reset asserted mid-play forces the reset values immediately (asynchronous), regardless of state.

## Test plan
- Reset and idle:
  - Stimulus: assert RESET_N=0, release, apply 5 ticks with no start.
  - Required: window=0, mem_addr=0, busy=0, song_done never pulses.
- Basic scroll, default parameters:
  - Stimulus: RAM rows 0..3 = 1010, 0101, 1111, 0001; start, then ticks spaced 4 cycles.
  - Required: after tick 1, the top row is 1010. After tick 8, hit_row=1010. After tick 9, hit_row=0101.
- Pending and overrun:
  - Stimulus: tick in PLAY, tick 1 cycle later, tick again 1 cycle after that.
  - Required: the second tick is applied when PLAY resumes; the third is dropped and overrun=1.
- End of song, LOOP=0, SONG_LEN=4:
  - Stimulus: 4+8 ticks.
  - Required: DRAIN is entered after tick 4; song_done pulses once after tick 12; window=0 and busy=0.
- Loop, LOOP=1, SONG_LEN=4:
  - Stimulus: 5 ticks.
  - Required: mem_addr sequence is 0,1,2,3,0; the 5th top row equals row 0; song_done is never asserted.
- Pause and restart:
  - Stimulus: pause=1 during 3 ticks, then start in the same cycle as a tick.
  - Required: the paused ticks have no effect; start wins over the tick, giving window=0, overrun=0 and PLAY 3 cycles later.

Source files
------------

// File: rtl/note_track_streamer.sv
// ---------------------------------------------------------------------------
// note_track_streamer
//
// Walks a preloaded song RAM one row per game tick and scrolls each row down
// a LANES-wide, DEPTH-tall note window. Row DEPTH-1 is the entry (top) row,
// row 0 is the hit zone. A small sequencer prefetches the next song row
// (FETCH -> WAIT -> PLAY) so a tick in PLAY can shift immediately; a tick that
// lands while the prefetch is in flight is held in a one-deep pending flag.
// When the song runs out the window is either refilled from address 0 (LOOP=1)
// or drained with zero rows until empty (LOOP=0).
//
// Ports:
//   CLK        system clock
//   RESET_N    asynchronous active-low reset
//   start      1-cycle pulse, (re)starts playback from address 0
//   tick       1-cycle game-step pulse
//   pause      level, ticks ignored while high
//   mem_addr   song RAM read address (registered)
//   mem_rdata  song RAM data, valid one cycle after mem_addr is sampled
//   window     bit [r*LANES+l] = lane l, row r
//   hit_row    row 0 of the window
//   busy       high outside IDLE and DONE
//   song_done  1-cycle pulse on entry to DONE
//   overrun    sticky, set when a tick is dropped
// ---------------------------------------------------------------------------
module note_track_streamer #(
    parameter int LANES    = 4,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 5,
    parameter int SONG_LEN = 32,
    parameter int LOOP     = 0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     pause,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [LANES-1:0]         mem_rdata,
    output logic [LANES*DEPTH-1:0]   window,
    output logic [LANES-1:0]         hit_row,
    output logic                     busy,
    output logic                     song_done,
    output logic                     overrun
);

    localparam int WIN_W = LANES * DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_W-1:0]      addr_reg, addr_next;
    logic [LANES-1:0]       prefetch_reg, prefetch_next;
    logic                   pending_reg, pending_next;
    logic [CNT_W-1:0]       drain_cnt_reg, drain_cnt_next;
    logic                   overrun_reg, overrun_next;
    logic [WIN_W-1:0]       window_reg, window_next;
    logic                   song_done_reg, song_done_next;

    logic                   tick_acc;
    logic                   step_now;
    logic [WIN_W-LANES-1:0] shifted_rows;
    logic [WIN_W-1:0]       shift_play;
    logic [WIN_W-1:0]       shift_drain;

    // Rows 0..DEPTH-2 take the row above them; the top row is supplied
    // separately (prefetched song row while playing, zeros while draining).
    generate
        for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_shift
            assign shifted_rows[gi*LANES +: LANES] = window_reg[(gi+1)*LANES +: LANES];
        end
    endgenerate

    assign shift_play  = {prefetch_reg, shifted_rows};
    assign shift_drain = {{LANES{1'b0}}, shifted_rows};

    assign tick_acc = tick & ~pause;
    // A held pending tick is consumed as soon as PLAY/DRAIN is reached.
    assign step_now = pending_reg | tick_acc;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            prefetch_reg  <= '0;
            pending_reg   <= 1'b0;
            drain_cnt_reg <= '0;
            overrun_reg   <= 1'b0;
            window_reg    <= '0;
            song_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            prefetch_reg  <= prefetch_next;
            pending_reg   <= pending_next;
            drain_cnt_reg <= drain_cnt_next;
            overrun_reg   <= overrun_next;
            window_reg    <= window_next;
            song_done_reg <= song_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        prefetch_next  = prefetch_reg;
        pending_next   = pending_reg;
        drain_cnt_next = drain_cnt_reg;
        overrun_next   = overrun_reg;
        window_next    = window_reg;
        song_done_next = 1'b0;

        if (start) begin
            state_next     = S_FETCH;
            addr_next      = '0;
            prefetch_next  = '0;
            pending_next   = 1'b0;
            drain_cnt_next = '0;
            overrun_next   = 1'b0;
            window_next    = '0;
        end else begin
            case (state_reg)
                S_FETCH, S_WAIT: begin
                    if (tick_acc) begin
                        if (pending_reg) begin
                            overrun_next = 1'b1;
                        end else begin
                            pending_next = 1'b1;
                        end
                    end
                    if (state_reg == S_FETCH) begin
                        state_next = S_WAIT;
                    end else begin
                        prefetch_next = mem_rdata;
                        state_next    = S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (step_now) begin
                        window_next  = shift_play;
                        // Pending goes first; a coincident new tick takes its slot.
                        pending_next = pending_reg & tick_acc;
                        if (addr_reg == LAST_ADDR) begin
                            if (LOOP != 0) begin
                                addr_next  = '0;
                                state_next = S_FETCH;
                            end else begin
                                drain_cnt_next = '0;
                                state_next     = S_DRAIN;
                            end
                        end else begin
                            addr_next  = addr_reg + ADDR_W'(1);
                            state_next = S_FETCH;
                        end
                    end
                end

                S_DRAIN: begin
                    if (step_now) begin
                        window_next    = shift_drain;
                        pending_next   = pending_reg & tick_acc;
                        drain_cnt_next = drain_cnt_reg + CNT_W'(1);
                        // DEPTH zero rows shifted in means the window is empty.
                        if (drain_cnt_reg == LAST_DRAIN) begin
                            state_next     = S_DONE;
                            song_done_next = 1'b1;
                            pending_next   = 1'b0;
                        end
                    end
                end

                S_IDLE, S_DONE: begin
                    // Ticks are ignored until the next start.
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = addr_reg;
    assign window    = window_reg;
    assign hit_row   = window_reg[LANES-1:0];
    assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign song_done = song_done_reg;
    assign overrun   = overrun_reg;

endmodule
